// File: rtl/reg_dump_pkg.sv
// Shared constants, FSM state type and helpers for the register dump block.
package reg_dump_pkg;

  // Architectural register width and register-file geometry
  localparam int WORD          = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int REG_AW        = 5;
  localparam int CNT_W         = 6;

  // Dump sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } dump_state_e;

  // Number of entries in an inclusive, wrapping index range first..last
  function automatic logic [CNT_W-1:0] entry_count(
    input logic [REG_AW-1:0] first_idx,
    input logic [REG_AW-1:0] last_idx
  );
    logic [REG_AW-1:0] span;
    span = last_idx - first_idx;
    return {1'b0, span} + 6'd1;
  endfunction

endpackage

// File: rtl/reg_dump.sv
// Register dump sequencer: walks a wrapping index range of an external
// register file and streams (index, value) pairs over a valid/ready port.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int DW       = WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [REG_AW-1:0] first_reg,
  input  logic [REG_AW-1:0] last_reg,
  output logic [REG_AW-1:0] r_reg,
  input  logic [DW-1:0]     r_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_idx,
  output logic [DW-1:0]     out_data,
  output logic              busy,
  output logic              done
);

  // Highest index before the address counter wraps back to zero
  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [REG_AW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer_s;
  logic [REG_AW-1:0] addr_next_s;

  // Handshake completion and wrapping address increment
  always_comb begin
    xfer_s = out_valid_q & out_ready;
    if (addr_q == LAST_IDX) begin
      addr_next_s = 5'd0;
    end else begin
      addr_next_s = addr_q + 5'd1;
    end
  end

  // Next-state, datapath and registered-output decode for the dump FSM
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          addr_d  = first_reg;
          rem_d   = entry_count(first_reg, last_reg);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        // Read port is combinational, so the value is valid this cycle
        out_idx_d  = addr_q;
        out_data_d = r_data;
        if (abort) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        // An entry accepted on the abort edge still counts as delivered
        if (xfer_s) begin
          rem_d = rem_q - 6'd1;
        end else begin
          rem_d = rem_q;
        end

        if (abort) begin
          state_d = ST_FIN;
        end else if (xfer_s) begin
          if (rem_q == 6'd1) begin
            state_d = ST_FIN;
          end else begin
            addr_d  = addr_next_s;
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_SEND;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of the upcoming state
    out_valid_d = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= 5'd0;
      rem_q       <= 6'd0;
      out_idx_q   <= 5'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign r_reg     = addr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Directed self-checking bench for reg_dump with a behavioural register file.
module tb_reg_dump;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  r_reg;
  logic [63:0] r_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [63:0] out_data;
  logic        busy;
  logic        done;

  logic [63:0] regfile [32];

  int checks;
  int errors;

  reg_dump #(.NUM_REGS(32), .DW(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .r_reg     (r_reg),
    .r_data    (r_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file read port, combinational with the address
  always_comb r_data = regfile[r_reg];

  // Hand-known register contents
  function automatic logic [63:0] exp_val(input logic [4:0] idx);
    if (idx == 5'd1) return 64'd123456789;
    if (idx == 5'd11) return 64'd100;
    return 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a dump with out_ready high and check the full entry stream
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input string tag);
    int          n_exp;
    int          n_got;
    logic [4:0]  span;
    logic [4:0]  ei;
    logic [4:0]  gi [64];
    logic [63:0] gd [64];
    bit          seen_done;
    span      = l - f;
    n_exp     = int'(span) + 1;
    n_got     = 0;
    seen_done = 1'b0;
    out_ready = 1'b1;
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_read_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    for (int c = 0; c < 200 && !seen_done; c++) begin
      tick();
      if (out_valid) begin
        if (n_got < 64) begin
          gi[n_got] = out_idx;
          gd[n_got] = out_data;
        end
        n_got++;
      end
      if (done) seen_done = 1'b1;
    end
    chk({tag, "_done_seen"}, {63'd0, seen_done}, 64'd1);
    chk({tag, "_count"}, 64'(n_got), 64'(n_exp));
    for (int k = 0; k < n_exp && k < n_got; k++) begin
      ei = f + 5'(k);
      chk({tag, "_idx"}, {59'd0, gi[k]}, {59'd0, ei});
      chk({tag, "_data"}, gd[k], exp_val(ei));
    end
    tick();
    chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done_end"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int          n_ent;
    bit          got_it;
    logic [4:0]  hold_idx;
    logic [63:0] hold_data;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    first_reg = 5'd0;
    last_reg  = 5'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regfile[i] = 64'd0;
    regfile[1]  = 64'd123456789;
    regfile[11] = 64'd100;

    tick();
    tick();
    chk("rst_r_reg", {59'd0, r_reg}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_idx", {59'd0, out_idx}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", {63'd0, busy}, 64'd0);
    chk("idle_abort_done", {63'd0, done}, 64'd0);

    run_dump(5'd0, 5'd31, "full");
    run_dump(5'd30, 5'd1, "wrap");

    // Single entry latency: READ after start edge, SEND after the next edge
    first_reg = 5'd11;
    last_reg  = 5'd11;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("one_lat_read", {63'd0, out_valid}, 64'd0);
    tick();
    chk("one_lat_send", {63'd0, out_valid}, 64'd1);
    chk("one_idx", {59'd0, out_idx}, 64'd11);
    chk("one_data", out_data, 64'd100);
    tick();
    chk("one_done", {63'd0, done}, 64'd1);
    chk("one_valid_fin", {63'd0, out_valid}, 64'd0);
    tick();
    chk("one_idle", {63'd0, busy}, 64'd0);

    // Back-pressure: out_ready low for 5 cycles in SEND
    out_ready = 1'b0;
    first_reg = 5'd1;
    last_reg  = 5'd1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("bp_valid0", {63'd0, out_valid}, 64'd1);
    hold_idx  = 5'd1;
    hold_data = 64'd123456789;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_idx", {59'd0, out_idx}, {59'd0, hold_idx});
      chk("bp_data", out_data, hold_data);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_done", {63'd0, done}, 64'd1);
    chk("bp_valid_end", {63'd0, out_valid}, 64'd0);
    tick();

    // Abort on the third SEND; a start while busy is ignored
    first_reg = 5'd0;
    last_reg  = 5'd31;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n_ent  = 0;
    got_it = 1'b0;
    for (int c = 0; c < 50 && !got_it; c++) begin
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (out_valid) begin
        chk("ab_idx", {59'd0, out_idx}, 64'(n_ent));
        n_ent++;
        if (n_ent == 1) begin
          first_reg = 5'd20;
          last_reg  = 5'd20;
          start     = 1'b1;
        end
        if (n_ent == 3) begin
          abort  = 1'b1;
          got_it = 1'b1;
        end
      end
    end
    chk("ab_reached", {63'd0, got_it}, 64'd1);
    tick();
    abort = 1'b0;
    chk("ab_done", {63'd0, done}, 64'd1);
    chk("ab_busy_fin", {63'd0, busy}, 64'd1);
    chk("ab_valid_fin", {63'd0, out_valid}, 64'd0);
    tick();
    chk("ab_busy_drop", {63'd0, busy}, 64'd0);
    chk("ab_done_drop", {63'd0, done}, 64'd0);
    chk("ab_valid_idle", {63'd0, out_valid}, 64'd0);
    chk("ab_count", 64'(n_ent), 64'd3);

    // Reset mid-dump, then a fresh dump
    first_reg = 5'd3;
    last_reg  = 5'd20;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_r_reg", {59'd0, r_reg}, 64'd0);
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_idx", {59'd0, out_idx}, 64'd0);
    chk("mrst_data", out_data, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_done", {63'd0, done}, 64'd0);
    tick();
    chk("mrst_stay_idle", {63'd0, busy}, 64'd0);
    run_dump(5'd0, 5'd31, "post_rst");
    run_dump(5'd10, 5'd12, "short");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
